// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with a blocking single-line refill engine.
// Hits are answered combinationally; misses stream BLKWORDS words from memory.
module icache_dm #(
   parameter int unsigned NSETS    = 16,
   parameter int unsigned BLKWORDS = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        invalidate,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [15:0] miss_count
);

   localparam int unsigned IW = $clog2(NSETS);
   localparam int unsigned WW = $clog2(BLKWORDS);
   localparam int unsigned CW = (WW > 0) ? WW : 1;
   localparam int unsigned TW = 32 - 2 - WW - IW;

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state_q, state_d;
   logic [NSETS-1:0]  valid_q, valid_d;
   logic [TW-1:0]     tag_q  [NSETS];
   logic [TW-1:0]     tag_d  [NSETS];
   logic [31:0]       data_q [NSETS][BLKWORDS];
   logic [31:0]       data_d [NSETS][BLKWORDS];
   logic [TW-1:0]     miss_tag_q, miss_tag_d;
   logic [IW-1:0]     miss_idx_q, miss_idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic [15:0]       miss_count_q, miss_count_d;

   logic [TW-1:0]     req_tag;
   logic [IW-1:0]     req_idx;
   logic [CW-1:0]     req_word;
   logic              lookup_hit;
   logic [31:0]       fill_addr;
   logic              unused_addr_bits;

   assign req_tag          = imemaddr[31 -: TW];
   assign req_idx          = imemaddr[2+WW +: IW];
   assign unused_addr_bits = ^imemaddr[1:0];

   // With one word per block there is no word field; the select is tied off.
   generate
      if (WW > 0) begin : g_word
         assign req_word = imemaddr[2 +: CW];
      end else begin : g_noword
         assign req_word = '0;
      end
   endgenerate

   always_comb begin
      lookup_hit = (state_q == IDLE) && imemREN && valid_q[req_idx]
                   && (tag_q[req_idx] == req_tag);
      ihit       = lookup_hit && !RST;
      imemload   = ihit ? data_q[req_idx][req_word] : '0;
      fill_addr  = {miss_tag_q, miss_idx_q, {(WW+2){1'b0}}} | (32'(cnt_q) << 2);
      iREN       = (state_q == FILL) && !RST;
      iaddr      = iREN ? fill_addr : '0;
   end

   assign miss_count = miss_count_q;

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      miss_tag_d   = miss_tag_q;
      miss_idx_d   = miss_idx_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      miss_count_d = miss_count_q;
      case (state_q)
         IDLE: begin
            if (invalidate) valid_d = '0;
            if (imemREN && !lookup_hit) begin
               miss_tag_d   = req_tag;
               miss_idx_d   = req_idx;
               cnt_d        = '0;
               miss_count_d = miss_count_q + 16'd1;
               state_d      = FILL;
            end
         end
         FILL: begin
            if (invalidate) pend_d = 1'b1;
            if (!iwait) begin
               data_d[miss_idx_q][cnt_q] = iload;
               cnt_d                     = cnt_q + 1'b1;
               if (cnt_q == CW'(BLKWORDS - 1)) begin
                  cnt_d   = '0;
                  state_d = IDLE;
                  // An invalidate seen anytime during the fill discards this line too.
                  if (pend_q || invalidate) begin
                     valid_d = '0;
                     pend_d  = 1'b0;
                  end else begin
                     tag_d[miss_idx_q]   = miss_tag_q;
                     valid_d[miss_idx_q] = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         miss_tag_q   <= '0;
         miss_idx_q   <= '0;
         cnt_q        <= '0;
         pend_q       <= 1'b0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         miss_tag_q   <= miss_tag_d;
         miss_idx_q   <= miss_idx_d;
         cnt_q        <= cnt_d;
         pend_q       <= pend_d;
         miss_count_q <= miss_count_d;
      end
   end

   always_ff @(posedge CLK) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm against an array-based cache/memory model.
module tb_icache_dm;
   localparam int unsigned NSETS    = 16;
   localparam int unsigned BLKWORDS = 2;
   localparam int unsigned WB       = $clog2(BLKWORDS);
   localparam int unsigned IB       = $clog2(NSETS);

   logic        CLK = 1'b0;
   logic        RST, imemREN, invalidate, iwait;
   logic [31:0] imemaddr, iload;
   logic        ihit, iREN;
   logic [31:0] imemload, iaddr;
   logic [15:0] miss_count;

   int checks = 0;
   int errors = 0;

   bit          m_valid [NSETS];
   int unsigned m_tag   [NSETS];
   logic [31:0] m_data  [NSETS][BLKWORDS];
   logic [15:0] m_misses;
   int unsigned gen;

   always #5 CLK = ~CLK;

   icache_dm #(.NSETS(NSETS), .BLKWORDS(BLKWORDS)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .invalidate(invalidate),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .miss_count(miss_count)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hAAAA0000 + (a - 32'h40) + (gen << 24);
   endfunction

   function automatic int unsigned idx_of(input logic [31:0] a);
      return (a >> (2 + WB)) % NSETS;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] a);
      return a >> (2 + WB + IB);
   endfunction

   function automatic int unsigned word_of(input logic [31:0] a);
      return (a >> 2) % BLKWORDS;
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One fetch: lookup, and on a miss the full refill, repeated until the model hits.
   task automatic fetch(input logic [31:0] addr, input int waits, input int inv_at);
      for (int a = 0; a < 3; a++) begin
         bit          hit_exp;
         logic [31:0] load_exp;
         logic [31:0] base;
         bit          pend;
         int          cyc;
         hit_exp  = model_hit(addr);
         load_exp = hit_exp ? m_data[idx_of(addr)][word_of(addr)] : 32'h0;
         imemREN = 1'b1; imemaddr = addr; invalidate = 1'b0;
         iwait = 1'($urandom); iload = $urandom;
         @(negedge CLK);
         checks++;
         if (ihit !== hit_exp) begin errors++; $display("FAIL lookup_ihit addr %h got %b exp %b", addr, ihit, hit_exp); end
         checks++;
         if (imemload !== load_exp) begin errors++; $display("FAIL lookup_data addr %h got %h exp %h", addr, imemload, load_exp); end
         checks++;
         if (iREN !== 1'b0 || iaddr !== 32'h0) begin errors++; $display("FAIL idle_mem addr %h got iREN %b iaddr %h exp 0 0", addr, iREN, iaddr); end
         checks++;
         if (miss_count !== m_misses) begin errors++; $display("FAIL miss_count got %h exp %h", miss_count, m_misses); end
         tick();
         if (hit_exp) break;
         m_misses = m_misses + 16'd1;
         base = addr & ~32'(BLKWORDS * 4 - 1);
         pend = 1'b0;
         cyc  = 0;
         for (int w = 0; w < BLKWORDS; w++) begin
            for (int k = 0; k <= waits; k++) begin
               logic [31:0] exp_addr;
               exp_addr   = base + 32'(4 * w);
               iwait      = (k < waits);
               iload      = (k < waits) ? $urandom : mem_word(exp_addr);
               invalidate = (a == 0) && (cyc == inv_at);
               if (invalidate) pend = 1'b1;
               imemREN    = 1'($urandom);
               imemaddr   = $urandom;
               @(negedge CLK);
               checks++;
               if (iREN !== 1'b1 || iaddr !== exp_addr) begin errors++; $display("FAIL fill_req cyc %0d got iREN %b iaddr %h exp 1 %h", cyc, iREN, iaddr, exp_addr); end
               checks++;
               if (ihit !== 1'b0) begin errors++; $display("FAIL fill_ihit cyc %0d got %b exp 0", cyc, ihit); end
               tick();
               cyc++;
            end
         end
         invalidate = 1'b0;
         if (pend) model_clear();
         else begin
            m_valid[idx_of(addr)] = 1'b1;
            m_tag[idx_of(addr)]   = tag_of(addr);
            for (int w = 0; w < BLKWORDS; w++)
               m_data[idx_of(addr)][w] = mem_word(base + 32'(4 * w));
         end
      end
      imemREN = 1'b0;
   endtask

   // Idle-cycle invalidate; the lookup in the same cycle sees the old valid bits.
   task automatic idle_invalidate(input logic [31:0] addr);
      bit          hit_exp;
      logic [31:0] load_exp;
      hit_exp  = model_hit(addr);
      load_exp = hit_exp ? m_data[idx_of(addr)][word_of(addr)] : 32'h0;
      imemREN = hit_exp; imemaddr = addr; invalidate = 1'b1;
      @(negedge CLK);
      checks++;
      if (ihit !== hit_exp || imemload !== load_exp) begin errors++; $display("FAIL inv_lookup got %b %h exp %b %h", ihit, imemload, hit_exp, load_exp); end
      tick();
      invalidate = 1'b0; imemREN = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; invalidate = 1'b0;
      iwait = 1'b0; iload = 32'h0;
      tick();
      @(negedge CLK);
      checks++;
      if (ihit !== 1'b0 || imemload !== 32'h0) begin errors++; $display("FAIL rst_hit got %b %h exp 0 0", ihit, imemload); end
      checks++;
      if (iREN !== 1'b0 || iaddr !== 32'h0) begin errors++; $display("FAIL rst_mem got %b %h exp 0 0", iREN, iaddr); end
      tick();
      checks++;
      if (miss_count !== 16'h0) begin errors++; $display("FAIL rst_count got %h exp 0", miss_count); end
      RST = 1'b0; imemREN = 1'b0;
      model_clear();
      m_misses = 16'h0;
   endtask

   task automatic test_cold_miss();
      gen = 0;
      fetch(32'h40, 0, -1);
   endtask

   task automatic test_hit();
      fetch(32'h44, 0, -1);
      checks++;
      if (miss_count !== 16'd1) begin errors++; $display("FAIL hit_count got %h exp 1", miss_count); end
   endtask

   task automatic test_conflict();
      gen = 1;
      fetch(32'h440, 0, -1);
      gen = 2;
      fetch(32'h40, 0, -1);
      checks++;
      if (miss_count !== 16'd3) begin errors++; $display("FAIL conflict_count got %h exp 3", miss_count); end
   endtask

   task automatic test_wait_states();
      fetch(32'h80, 3, -1);
   endtask

   task automatic test_invalidate();
      idle_invalidate(32'h44);
      fetch(32'h100, 0, -1);
      fetch(32'h40, 0, 1);
      fetch(32'h100, 0, -1);
   endtask

   task automatic test_reset_midfill();
      idle_invalidate(32'h0);
      imemREN = 1'b1; imemaddr = 32'h40;
      tick();
      RST = 1'b1;
      @(negedge CLK);
      checks++;
      if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin errors++; $display("FAIL midrst_during got %b %h %b exp 0 0 0", iREN, iaddr, ihit); end
      tick();
      RST = 1'b0; imemREN = 1'b0;
      @(negedge CLK);
      checks++;
      if (iREN !== 1'b0 || iaddr !== 32'h0 || miss_count !== 16'h0) begin errors++; $display("FAIL midrst_after got %b %h %h exp 0 0 0", iREN, iaddr, miss_count); end
      tick();
      model_clear();
      m_misses = 16'h0;
      fetch(32'h40, 0, -1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         a   = $urandom_range(0, 4 * NSETS * BLKWORDS * 4 - 1);
         gen = $urandom_range(0, 255);
         if ($urandom_range(0, 15) == 0) idle_invalidate(a);
         else fetch(a, $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1);
      end
   endtask

   initial begin
      RST = 1'b1; imemREN = 1'b0; imemaddr = '0; invalidate = 1'b0;
      iwait = 1'b0; iload = '0; gen = 0; m_misses = '0;
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_wait_states();
      test_invalidate();
      test_reset_midfill();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
